jtsdram_bank_rsp: RTL and testbench
===================================

Name: jtsdram_bank_rsp

Overview:
Simulation-grade SDRAM responder: the memory-side end of the 4-bank ba*_rd/ba*_wr/ack/rdy client interface driven by the SDRAM checker.
- Arbitrates the four banks round-robin.
- Services each request from a small internal per-bank array with fixed latency.
- Blocks service during periodic refresh windows.
- Gives the checker a deterministic partner in testbenches and FPGA self-loop builds.

Parameters:
- AW, 10: word-address bits per bank; array depth 2^AW 16-bit words per bank.
- LAT, 4: cycles from the ack pulse to the rdy pulse; legal range 2..15.
- REF_PERIOD, 384: clk cycles between refresh requests.
- REF_CYC, 8: cycles the responder stays busy per refresh.
- BAD_N, 256: read count between injected errors; used only with the optional feature.

Ports:
- clk  in  1  system clock, 48 MHz.
- rst  in  1  synchronous reset, active-high.
- ba0_addr, ba1_addr, ba2_addr, ba3_addr  in  22 each  16-bit word address per bank.
- ba_rd  in  4  read request per bank; bit n belongs to bank n.
- ba0_wr  in  1  write request; bank 0 only.
- ba0_din  in  16  write data.
- ba0_din_m  in  2  byte write mask; 1 = byte NOT written; bit1 is the upper byte.
- refresh_en  in  1  enables the periodic refresh windows.
- ba_ack  out  4  one-cycle pulse when a request is accepted.
- ba_rdy  out  4  one-cycle pulse when the access completes.
- data_read  out  32  read data; valid in the cycle ba_rdy pulses, then held.

Behaviour:
- Reset:
  - ba_ack=0, ba_rdy=0, data_read=0.
  - FSM goes to IDLE, round-robin pointer=0, refresh counter=0.
  - A transaction in flight is dropped and gets no rdy.
  - Array contents are not cleared.
- Request rule:
  - A request is live while ba_rd[n] (or ba0_wr for bank 0) is high.
  - Clients hold the request until ack; dropping it before ack is legal and simply withdraws it.
- FSM states: IDLE, ACK, WAIT, RDY, REFRESH.
- IDLE:
  - Refresh due and refresh_en=1 → REFRESH. Refresh has priority over any pending request.
  - Otherwise, if any request is live, the arbiter picks bank = first live bank at or after the pointer (wrapping 3→0).
  - Latch bank, addr[AW-1:0], kind (rd/wr), din, mask → ACK.
- ACK:
  - ba_ack[bank]=1 for this single cycle.
  - Pointer ← bank+1 mod 4.
  - A write is applied to the array in this cycle.
  - Latency counter loaded with LAT-2 → WAIT.
- WAIT: count down; at 0 → RDY. Total ack-to-rdy distance is exactly LAT cycles.
- RDY:
  - ba_rdy[bank]=1 for one cycle.
  - Read: data_read = {mem[bank][a+1], mem[bank][a]}, with a+1 wrapping modulo 2^AW.
  - Write: data_read keeps its previous value.
  - Next state is IDLE; the earliest next ack is 2 cycles after rdy.
- Simultaneous ba_rd[0] and ba0_wr: the access is treated as a write and no read is performed.
- Write masking: a byte is written only where its mask bit is 0. Mask 2'b11 is a legal no-op that still acks and rdys.
- Address bits above AW-1 are ignored, so addresses alias.
- Refresh counter:
  - Increments every cycle while refresh_en=1, saturating at REF_PERIOD (pending).
  - Cleared on entering REFRESH.
  - Holds its value while refresh_en=0.
- REFRESH: no acks for REF_CYC cycles → IDLE. A request arriving during refresh waits.
- Only one transaction is outstanding at a time; there is no pipelining.

Optional Feature:
- Macro JTSDRAM_BADINJ_EN.
- Defined: a 16-bit read counter shared by all banks counts completed reads. On every read where the count hits a multiple of BAD_N, data_read[0] is inverted in the RDY cycle, exercising the checker's bad-flag path. The counter resets to 0.
- Undefined: data is always exact and the counter logic is absent.

Decomposition:
- Package jtsdram_pkg holds:
  - FSM state encoding (localparams ST_IDLE..ST_REFRESH).
  - NBANKS=4.
  - Default LAT, REF_PERIOD, REF_CYC.
- Sub-module jtsdram_rr_arb holds the 4-way round-robin arbiter.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: gnt_valid, gnt_id[1:0].
  - Purely combinational.
- Pointer update stays in the parent.

Test Plan:
1. Reset, then ba0_wr at addr 0x10 with din=0xA55A, mask=00; then ba_rd[0] at addr 0x10 → ack at T; rdy at T+4 (LAT=4); data_read[15:0]=0xA55A.
2. Write 0x1234 mask=01 over an existing 0xFFFF → read returns 0x12FF; mask=11 → value unchanged, ack and rdy still pulse.
3. All four ba_rd held high continuously from the pointer-0 state → acks are granted in order 0,1,2,3,0; exactly one ack per transaction and a rdy after each.
4. refresh_en=1, REF_PERIOD=384, constant requests → after 384 cycles an 8-cycle gap with no ack; ack-to-rdy spacing stays LAT throughout.
5. rst asserted in WAIT → no rdy ever follows; after release, previously written data is still readable; data_read=0 immediately after reset.
6. With JTSDRAM_BADINJ_EN and BAD_N=4 → reads 4, 8, 12 return bit0 inverted and all other reads are exact.

Source files
------------

// File: rtl/jtsdram_pkg.sv
// Shared definitions for the jtsdram bank responder: FSM encoding, bank count
// and default timing values.
package jtsdram_pkg;

  localparam int NBANKS         = 4;
  localparam int DEF_LAT        = 4;
  localparam int DEF_REF_PERIOD = 384;
  localparam int DEF_REF_CYC    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACK     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RDY     = 3'd3,
    ST_REFRESH = 3'd4
  } state_e;

  // One-hot strobe for a bank index, used for the ack/rdy pulse vectors.
  function automatic logic [NBANKS-1:0] bank_onehot(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/jtsdram_rr_arb.sv
// Four-way round-robin arbiter: grants the first requesting bank at or after
// ptr, wrapping 3 -> 0. Purely combinational; the pointer lives in the parent.
module jtsdram_rr_arb
  import jtsdram_pkg::*;
(
  input  logic [NBANKS-1:0] req,
  input  logic [1:0]        ptr,
  output logic              gnt_valid,
  output logic [1:0]        gnt_id
);

  logic [1:0] idx;

  // Scan offsets from the farthest to the nearest so the nearest live bank wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 2'd0;
    idx       = 2'd0;
    for (int i = NBANKS - 1; i >= 0; i--) begin
      idx = ptr + i[1:0];
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/jtsdram_bank_rsp.sv
// Simulation-grade SDRAM responder for the 4-bank rd/wr/ack/rdy client port.
// One transaction at a time, fixed ack-to-rdy latency of LAT cycles, periodic
// refresh windows, per-bank 16-bit word arrays of depth 2^AW.
// Optional macro JTSDRAM_BADINJ_EN: flips data_read[0] on every BAD_N-th
// completed read so the checker's error path gets exercised.
module jtsdram_bank_rsp
  import jtsdram_pkg::*;
#(
  parameter int AW         = 10,
  parameter int LAT        = DEF_LAT,
  parameter int REF_PERIOD = DEF_REF_PERIOD,
  parameter int REF_CYC    = DEF_REF_CYC,
  parameter int BAD_N      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [21:0] ba0_addr,
  input  logic [21:0] ba1_addr,
  input  logic [21:0] ba2_addr,
  input  logic [21:0] ba3_addr,
  input  logic [3:0]  ba_rd,
  input  logic        ba0_wr,
  input  logic [15:0] ba0_din,
  input  logic [1:0]  ba0_din_m,
  input  logic        refresh_en,
  output logic [3:0]  ba_ack,
  output logic [3:0]  ba_rdy,
  output logic [31:0] data_read
);

  localparam int RCW = $clog2(REF_PERIOD + 1);
  localparam int YCW = $clog2(REF_CYC + 1);

  if (LAT < 2 || LAT > 15 || BAD_N < 1 || REF_CYC < 1) begin : g_param_chk
    $error("jtsdram_bank_rsp: LAT must be 2..15, BAD_N and REF_CYC at least 1");
  end

  state_e          state_q;
  logic [1:0]      ptr_q, bank_q;
  logic [AW-1:0]   addr_q, addr_nxt;
  logic            wr_q;
  logic [15:0]     din_q;
  logic [1:0]      mask_q;
  logic [3:0]      lat_q;
  logic [YCW-1:0]  rcyc_q;
  logic [RCW-1:0]  refc_q;
  logic [3:0]      ack_q, rdy_q;
  logic [31:0]     data_q;
  logic [15:0]     mem_q [NBANKS * (2 ** AW)];

  logic [3:0]      req_live;
  logic            gnt_valid;
  logic [1:0]      gnt_id;
  logic [21:0]     sel_addr;
  logic            ref_due, enter_ref, read_done;
  logic [31:0]     rd_word;
  logic            unused_addr_bits;

  // Upper address bits alias onto the array and are deliberately dropped.
  assign unused_addr_bits = ^{ba0_addr[21:AW], ba1_addr[21:AW],
                              ba2_addr[21:AW], ba3_addr[21:AW], sel_addr[21:AW]};

  assign req_live  = ba_rd | {3'b000, ba0_wr};
  assign ref_due   = (refc_q == RCW'(REF_PERIOD));
  assign enter_ref = (state_q == ST_IDLE) && refresh_en && ref_due;
  assign read_done = (state_q == ST_WAIT) && (lat_q == 4'd0) && !wr_q;
  assign addr_nxt  = addr_q + AW'(1);

  jtsdram_rr_arb u_arb (
    .req       (req_live),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Address of the bank the arbiter is about to grant.
  always_comb begin
    sel_addr = ba0_addr;
    case (gnt_id)
      2'd1:    sel_addr = ba1_addr;
      2'd2:    sel_addr = ba2_addr;
      2'd3:    sel_addr = ba3_addr;
      default: sel_addr = ba0_addr;
    endcase
  end

`ifdef JTSDRAM_BADINJ_EN
  logic [15:0] rdcnt_q, rdcnt_inc;
  logic        bad_hit;

  assign rdcnt_inc = rdcnt_q + 16'd1;
  assign bad_hit   = (rdcnt_inc % 16'(BAD_N)) == 16'd0;
  assign rd_word   = {mem_q[{bank_q, addr_nxt}], mem_q[{bank_q, addr_q}]} ^ {31'd0, bad_hit};

  // Completed-read counter shared by all banks.
  always_ff @(posedge clk) begin
    if (rst) rdcnt_q <= '0;
    else if (read_done) rdcnt_q <= rdcnt_inc;
  end
`else
  assign rd_word = {mem_q[{bank_q, addr_nxt}], mem_q[{bank_q, addr_q}]};
`endif

  // Refresh request counter: saturates at REF_PERIOD, frozen while disabled.
  always_ff @(posedge clk) begin
    if (rst) refc_q <= '0;
    else if (enter_ref) refc_q <= '0;
    else if (refresh_en && !ref_due) refc_q <= refc_q + RCW'(1);
  end

  // Byte-masked write, committed during the ACK cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_ACK && wr_q) begin
      if (!mask_q[0]) mem_q[{bank_q, addr_q}][7:0]  <= din_q[7:0];
      if (!mask_q[1]) mem_q[{bank_q, addr_q}][15:8] <= din_q[15:8];
    end
  end

  // Transaction FSM with registered ack/rdy/data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      bank_q  <= 2'd0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      din_q   <= 16'd0;
      mask_q  <= 2'd0;
      lat_q   <= 4'd0;
      rcyc_q  <= '0;
      ack_q   <= 4'd0;
      rdy_q   <= 4'd0;
      data_q  <= 32'd0;
    end else begin
      ack_q <= 4'd0;
      rdy_q <= 4'd0;
      case (state_q)
        ST_IDLE: begin
          if (enter_ref) begin
            state_q <= ST_REFRESH;
            rcyc_q  <= YCW'(REF_CYC - 1);
          end else if (gnt_valid) begin
            state_q <= ST_ACK;
            bank_q  <= gnt_id;
            addr_q  <= sel_addr[AW-1:0];
            wr_q    <= (gnt_id == 2'd0) && ba0_wr;
            din_q   <= ba0_din;
            mask_q  <= ba0_din_m;
            ack_q   <= bank_onehot(gnt_id);
          end
        end
        ST_ACK: begin
          ptr_q   <= bank_q + 2'd1;
          lat_q   <= 4'(LAT - 2);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_q == 4'd0) begin
            state_q <= ST_RDY;
            rdy_q   <= bank_onehot(bank_q);
            if (!wr_q) data_q <= rd_word;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        ST_RDY: state_q <= ST_IDLE;
        ST_REFRESH: begin
          if (rcyc_q == '0) state_q <= ST_IDLE;
          else rcyc_q <= rcyc_q - YCW'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ba_ack    = ack_q;
  assign ba_rdy    = rdy_q;
  assign data_read = data_q;

endmodule

// File: tb/tb_jtsdram_bank_rsp.sv
// Bench for jtsdram_bank_rsp: directed steps plus randomized request sets,
// checked against a transaction-level model (per-bank word arrays, a
// round-robin pointer and the refresh schedule).
module tb_jtsdram_bank_rsp;

  localparam int AW         = 10;
  localparam int LAT        = 4;
  localparam int REF_PERIOD = 384;
  localparam int REF_CYC    = 8;
  localparam int BAD_N      = 4;
  localparam int DEPTH      = 2 ** AW;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic [3:0]  ba_rd;
  logic        ba0_wr;
  logic [15:0] ba0_din;
  logic [1:0]  ba0_din_m;
  logic        refresh_en;
  logic [3:0]  ba_ack, ba_rdy;
  logic [31:0] data_read;

  always #5 clk = ~clk;

  jtsdram_bank_rsp #(
    .AW(AW), .LAT(LAT), .REF_PERIOD(REF_PERIOD), .REF_CYC(REF_CYC), .BAD_N(BAD_N)
  ) dut (
    .clk(clk), .rst(rst),
    .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba_rd(ba_rd), .ba0_wr(ba0_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
    .refresh_en(refresh_en),
    .ba_ack(ba_ack), .ba_rdy(ba_rdy), .data_read(data_read)
  );

  // ---------------- model / scoreboard ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] ref_mem   [4][DEPTH];
  bit          ref_known [4][DEPTH];
  logic [31:0] exp_data;
  bit          exp_known;
  int          ptr_m;
  int          rd_count_m;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit [3:0] pend, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (pend[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_dut(input bit ref_on, input logic [3:0] hold);
    rst        = 1'b1;
    refresh_en = ref_on;
    ba_rd      = hold;
    ba0_wr     = 1'b0;
    step();
    step();
    chk("reset_ack", ba_ack, 0);
    chk("reset_rdy", ba_rdy, 0);
    chk("reset_data", data_read, 0);
    rst        = 1'b0;
    cyc        = 0;
    ptr_m      = 0;
    rd_count_m = 0;
    exp_data   = 32'd0;
    exp_known  = 1'b1;
  endtask

  // Raise a set of requests together; each client drops its request on ack.
  task automatic serve_set(input bit [3:0] rd_set, input bit wr0,
                           input logic [21:0] a0, input logic [21:0] a1,
                           input logic [21:0] a2, input logic [21:0] a3,
                           input logic [15:0] din, input logic [1:0] m);
    bit [3:0]    pend;
    logic [21:0] addr_l [4];
    logic [9:0]  a, an;
    logic [31:0] e;
    int          b, n;
    bit          first, is_wr;
    addr_l[0] = a0; addr_l[1] = a1; addr_l[2] = a2; addr_l[3] = a3;
    ba0_addr = a0; ba1_addr = a1; ba2_addr = a2; ba3_addr = a3;
    ba0_din = din; ba0_din_m = m;
    ba_rd = rd_set; ba0_wr = wr0;
    pend  = rd_set | {3'b000, wr0};
    first = 1'b1;
    while (pend != 0) begin
      b = pick(pend, ptr_m);
      n = 0;
      do begin step(); n++; end while (ba_ack == 4'd0 && n < 40);
      chk("ack_bank", ba_ack, 4'b0001 << b);
      if (!first) chk("rdy_to_next_ack", n, 2);
      ba_rd[b] = 1'b0;
      if (b == 0) ba0_wr = 1'b0;
      pend[b] = 1'b0;
      ptr_m   = (b + 1) % 4;
      is_wr   = (b == 0) && wr0;
      a  = addr_l[b][9:0];
      an = a + 10'd1;
      if (is_wr) begin
        if (!m[0]) ref_mem[0][a][7:0]  = din[7:0];
        if (!m[1]) ref_mem[0][a][15:8] = din[15:8];
        ref_known[0][a] = ref_known[0][a] | (m == 2'b00);
      end
      n = 0;
      do begin
        step(); n++;
        if (ba_ack != 4'd0) chk("ack_during_txn", ba_ack, 0);
      end while (ba_rdy == 4'd0 && n < 40);
      chk("ack_to_rdy", n, LAT);
      chk("rdy_bank", ba_rdy, 4'b0001 << b);
      if (!is_wr) begin
        rd_count_m++;
        exp_known = ref_known[b][a] && ref_known[b][an];
        e = {ref_mem[b][an], ref_mem[b][a]};
`ifdef JTSDRAM_BADINJ_EN
        if (rd_count_m % BAD_N == 0) e[0] = ~e[0];
`endif
        exp_data = e;
      end
      if (exp_known) begin
        exp_q.push_back(exp_data);
        chk("data_read", data_read, exp_q.pop_front());
      end
      first = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int last_ack, nack, exp_gap, n_rdy;
    bit ref_done;
    logic [9:0] ra;
    ba0_addr = '0; ba1_addr = '0; ba2_addr = '0; ba3_addr = '0;
    ba0_din = '0; ba0_din_m = '0;

    // Basic write then read at 0x10.
    reset_dut(1'b0, 4'd0);
    serve_set(4'b0000, 1'b1, 22'h10, 0, 0, 0, 16'hA55A, 2'b00);
    serve_set(4'b0001, 1'b0, 22'h10, 0, 0, 0, 16'h0, 2'b00);
`ifndef JTSDRAM_BADINJ_EN
    chk("t1_low_word", data_read[15:0], 16'hA55A);
`endif

    // Fill bank 0 words 0x00..0x21 and 0x3FF so later reads are predictable.
    for (int i = 0; i <= 16'h21; i++) begin
      if (i != 16'h10) serve_set(4'b0000, 1'b1, 22'(i), 0, 0, 0, 16'($urandom), 2'b00);
    end
    serve_set(4'b0000, 1'b1, 22'h3FF, 0, 0, 0, 16'($urandom), 2'b00);

    // Byte masks: upper byte only, then a full no-op mask.
    serve_set(4'b0000, 1'b1, 22'h20, 0, 0, 0, 16'hFFFF, 2'b00);
    serve_set(4'b0000, 1'b1, 22'h20, 0, 0, 0, 16'h1234, 2'b01);
    serve_set(4'b0001, 1'b0, 22'h20, 0, 0, 0, 16'h0, 2'b00);
    serve_set(4'b0000, 1'b1, 22'h20, 0, 0, 0, 16'h5678, 2'b11);
    serve_set(4'b0001, 1'b0, 22'h20, 0, 0, 0, 16'h0, 2'b00);
`ifndef JTSDRAM_BADINJ_EN
    chk("mask11_keeps", data_read[15:0], 16'h12FF);
`endif

    // Simultaneous rd[0]+wr is a write; aliased address and wrap at 0x3FF.
    serve_set(4'b0001, 1'b1, 22'h05, 0, 0, 0, 16'hBEEF, 2'b00);
    serve_set(4'b0001, 1'b0, 22'h3FFC05, 0, 0, 0, 16'h0, 2'b00);
    serve_set(4'b0001, 1'b0, 22'h0013FF, 0, 0, 0, 16'h0, 2'b00);

    // Randomized request sets across all banks.
    for (int it = 0; it < 40; it++) begin
      bit [3:0] rs;
      bit       w;
      rs = 4'($urandom_range(0, 15));
      w  = 1'($urandom_range(0, 1));
      if (rs == 4'd0 && !w) rs = 4'b0001;
      ra = w ? 10'($urandom_range(0, 16'h21)) : 10'($urandom_range(0, 16'h20));
      if (!w && $urandom_range(0, 7) == 0) ra = 10'h3FF;
      serve_set(rs, w, {12'($urandom), ra}, 22'($urandom), 22'($urandom), 22'($urandom),
                16'($urandom), 2'($urandom_range(0, 3)));
    end

    // Reset while a read is waiting: no rdy afterwards, array preserved.
    ba0_addr = 22'h10; ba_rd = 4'b0001;
    n_rdy = 0;
    for (int k = 0; k < 40 && ba_ack == 4'd0; k++) step();
    chk("pre_reset_ack", ba_ack, 4'b0001);
    ba_rd = 4'b0000;
    step();
    reset_dut(1'b0, 4'd0);
    for (int k = 0; k < 12; k++) begin
      step();
      if (ba_rdy != 4'd0) n_rdy++;
    end
    chk("no_rdy_after_reset", n_rdy, 0);
    serve_set(4'b0001, 1'b0, 22'h10, 0, 0, 0, 16'h0, 2'b00);

    // All banks held continuously with refresh enabled from reset.
    reset_dut(1'b1, 4'b1111);
    last_ack = 0; nack = 0; ref_done = 1'b0;
    for (int k = 0; k < 450; k++) begin
      step();
      if (ba_ack != 4'd0) begin
        chk("rr_order", ba_ack, 4'b0001 << (nack % 4));
        if (nack == 0) chk("first_ack_cycle", cyc, 1);
        else begin
          exp_gap = LAT + 2;
          if (!ref_done && last_ack + LAT + 1 >= REF_PERIOD) begin
            exp_gap  = LAT + 2 + REF_CYC + 1;
            ref_done = 1'b1;
          end
          chk("ack_gap", cyc - last_ack, exp_gap);
        end
        last_ack = cyc;
        nack++;
      end
      if (ba_rdy != 4'd0) begin
        chk("rr_rdy_bank", ba_rdy, 4'b0001 << ((nack - 1) % 4));
        chk("rr_ack_to_rdy", cyc - last_ack, LAT);
      end
    end
    ba_rd = 4'b0000;

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
